regfile_fifo_ctrl: RTL and testbench

//  Write/read sequencer sitting directly upstream of the 4-entry register file; turns it into a 4-deep FIFO.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/wrap_ptr.sv | 26 ++
 rtl/regfile_fifo_ctrl.sv | 141 ++++++++++++++
 tb/tb_regfile_fifo_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and the occupancy state type for the register-file FIFO controller.
package regfile_pkg;

  localparam int N     = 4;        // data width, same as the register file
  localparam int AW    = 2;        // address width
  localparam int DEPTH = 1 << AW;  // number of register file entries

  // Occupancy classes; the exact fill level lives in the count register.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_state_t;

endpackage

// File: rtl/wrap_ptr.sv
// AW-bit wrapping pointer: increments on en, rolls from max back to 0,
// synchronous clear has priority over the increment.
module wrap_ptr #(
  parameter int AW = regfile_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [AW-1:0] ptr
);

  // Pointer register; natural AW-bit overflow provides the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values, independent of the order the simulator runs processes.
    end else if (en) begin
      ptr <= ptr + AW'(1);
    end
  end

endmodule

// File: rtl/regfile_fifo_ctrl.sv
// Write/read sequencer that turns a 4-entry register file with a
// combinational read port into a FIFO with valid/ready streams on both sides.
module regfile_fifo_ctrl #(
  parameter int N  = regfile_pkg::N,
  parameter int AW = regfile_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  input  logic          flush,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          proto_err,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [N-1:0]  rf_din,
  output logic [AW-1:0] rf_raddr,
  input  logic [N-1:0]  rf_dout
);

  import regfile_pkg::*;

  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(1 << AW);

  occ_state_t    state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wptr, rptr;
  logic          push, pop;
  logic          stall_q;
  logic [N-1:0]  stall_data_q;
  logic          proto_err_q;

  // Handshakes: flush blocks both sides for its cycle; reset blocks the producer.
  assign full      = (state_q == FULL);
  assign empty     = (state_q == EMPTY);
  assign count     = count_q;
  assign in_ready  = !full && !flush && !rst;
  assign out_valid = !empty && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign proto_err = proto_err_q;

  // Register file hookup: write at wptr this cycle, head is read at rptr.
  assign rf_we    = push;
  assign rf_waddr = wptr;
  assign rf_din   = in_data;
  assign rf_raddr = rptr;
  assign out_data = rf_dout;

  wrap_ptr #(.AW(AW)) u_wptr (
    .clk (clk),
    .rst (rst),
    .en  (push),
    .clr (flush),
    .ptr (wptr)
  );

  wrap_ptr #(.AW(AW)) u_rptr (
    .clk (clk),
    .rst (rst),
    .en  (pop),
    .clr (flush),
    .ptr (rptr)
  );

  // Occupancy next-state: flush wins, otherwise count tracks push minus pop.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch forms.
    state_d = state_q;
    count_d = count_q;
    if (flush) begin
      state_d = EMPTY;
      count_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = PARTIAL;
            count_d = CNT_ONE;
          end
        end
        PARTIAL: begin
          if (push && !pop) begin
            count_d = count_q + CNT_ONE;
            if (count_q == CNT_FULL - CNT_ONE) state_d = FULL;
          end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
            if (count_q == CNT_ONE) state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = PARTIAL;
            count_d = count_q - CNT_ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          count_d = '0;
        end
      endcase
    end
  end

  // Occupancy state and count registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: reset only clears pointers and count; the register file itself is
    // never reset because an entry is always rewritten before it is read.
    if (rst) begin
      state_q <= EMPTY;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Sticky producer-protocol monitor: a stalled offer must be held unchanged
  // on the following cycle unless a flush intervenes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q      <= 1'b0;
      stall_data_q <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      if (stall_q && !flush && (!in_valid || (in_data != stall_data_q))) begin
        proto_err_q <= 1'b1;
      end
      stall_q      <= in_valid && !in_ready && !flush;
      stall_data_q <= in_data;
    end
  end

endmodule

// File: tb/tb_regfile_fifo_ctrl.sv
// Bench for regfile_fifo_ctrl paired with a 4-entry register file model.
// A queue-based reference model is compared against the DUT every cycle,
// and directed steps pin hand-computed values.
module tb_regfile_fifo_ctrl;

  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  out_data;
  logic          flush = 1'b0;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          proto_err;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [N-1:0]  rf_din;
  logic [AW-1:0] rf_raddr;
  logic [N-1:0]  rf_dout;

  always #5 clk = ~clk;

  regfile_fifo_ctrl #(.N(N), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .proto_err (proto_err),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_din    (rf_din),
    .rf_raddr  (rf_raddr),
    .rf_dout   (rf_dout)
  );

  // Register file: synchronous write, combinational read.
  logic [N-1:0] rf_mem [4];
  always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_din;
  assign rf_dout = rf_mem[rf_raddr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue plus push/pop tallies.
  logic [N-1:0] mq[$];
  int           wcnt = 0;
  int           rcnt = 0;
  bit           m_proto = 1'b0;
  bit           m_stall = 1'b0;
  logic [N-1:0] m_sd = '0;
  bit           m_rdy, m_push, m_pop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      wcnt = 0;
      rcnt = 0;
      m_proto = 1'b0;
      m_stall = 1'b0;
    end else begin
      m_rdy  = (mq.size() < 4) && !flush;
      m_push = in_valid && m_rdy;
      m_pop  = (mq.size() > 0) && !flush && out_ready;
      if (m_stall && !flush && (!in_valid || (in_data !== m_sd))) m_proto = 1'b1;
      m_stall = in_valid && !m_rdy && !flush;
      m_sd    = in_data;
      if (flush) begin
        mq.delete();
        wcnt = 0;
        rcnt = 0;
      end else begin
        if (m_pop) begin
          void'(mq.pop_front());
          rcnt++;
        end
        if (m_push) begin
          mq.push_back(in_data);
          wcnt++;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  int sz;
  bit e_rdy, e_ov, e_we;
  always @(negedge clk) begin
    sz    = mq.size();
    e_rdy = !rst && (sz < 4) && !flush;
    e_ov  = (sz > 0) && !flush;
    e_we  = in_valid && e_rdy;
    check("in_ready", in_ready, e_rdy);
    check("out_valid", out_valid, e_ov);
    check("count", count, sz);
    check("full", full, sz == 4);
    check("empty", empty, sz == 0);
    check("rf_we", rf_we, e_we);
    check("proto_err", proto_err, m_proto);
    check("rf_waddr", rf_waddr, wcnt % 4);
    check("rf_raddr", rf_raddr, rcnt % 4);
    if (e_ov) check("out_data", out_data, mq[0]);
    if (e_we) check("rf_din", rf_din, in_data);
  end

  task automatic step(input logic v, input logic [N-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst rf_we", rf_we, 0);
    check("rst empty", empty, 1);
    check("rst full", full, 0);
    check("rst count", count, 0);
    check("rst proto_err", proto_err, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("in_ready after rst", in_ready, 1);

    // 1. Fill and drain
    for (int i = 0; i < 4; i++) step(1'b1, N'(10 + i), 1'b0, 1'b0);
    idle();
    check("t1 full", full, 1);
    check("t1 in_ready", in_ready, 0);
    check("t1 count", count, 4);
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1;
      #1 check("t1 drain data", out_data, 10 + i);
      step(1'b0, '0, 1'b1, 1'b0);
    end
    idle();
    check("t1 empty", empty, 1);

    // Preamble: three push/pop pairs leave both pointers at 3
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'h9, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
    end
    idle();
    check("pre waddr", rf_waddr, 3);

    // 2. Wrap
    for (int i = 1; i <= 3; i++) step(1'b1, N'(i), 1'b0, 1'b0);
    for (int i = 1; i <= 2; i++) begin
      idle();
      check("t2 pop data", out_data, i);
      step(1'b0, '0, 1'b1, 1'b0);
    end
    for (int i = 4; i <= 6; i++) step(1'b1, N'(i), 1'b0, 1'b0);
    idle();
    check("t2 count", count, 4);
    check("t2 full", full, 1);
    check("t2 waddr wrapped", rf_waddr, 1);
    for (int i = 3; i <= 6; i++) begin
      idle();
      check("t2 drain data", out_data, i);
      step(1'b0, '0, 1'b1, 1'b0);
    end
    idle();
    check("t2 empty", empty, 1);

    // 3. Simultaneous push and pop at count 2
    step(1'b1, 4'h5, 1'b0, 1'b0);
    step(1'b1, 4'h6, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      in_valid  = 1'b1;
      in_data   = N'(7 + i);
      out_ready = 1'b1;
      #1;
      check("t3 rf_we", rf_we, 1);
      check("t3 count", count, 2);
      check("t3 out_data", out_data, 5 + i);
      step(1'b1, N'(7 + i), 1'b1, 1'b0);
    end
    for (int i = 11; i <= 12; i++) begin
      idle();
      check("t3 tail data", out_data, i);
      step(1'b0, '0, 1'b1, 1'b0);
    end
    idle();
    check("t3 empty", empty, 1);

    // 4. Flush at count 3 with a push offered
    for (int i = 1; i <= 3; i++) step(1'b1, N'(i), 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 4'hf;
    flush    = 1'b1;
    #1;
    check("t4 flush rf_we", rf_we, 0);
    check("t4 flush out_valid", out_valid, 0);
    check("t4 flush in_ready", in_ready, 0);
    step(1'b1, 4'hf, 1'b0, 1'b1);
    idle();
    check("t4 count", count, 0);
    check("t4 empty", empty, 1);
    step(1'b1, 4'he, 1'b0, 1'b0);
    idle();
    check("t4 out_valid", out_valid, 1);
    check("t4 readback", out_data, 4'he);
    step(1'b0, '0, 1'b1, 1'b0);
    idle();

    // 5. Asynchronous reset mid-stream at count 2
    step(1'b1, 4'h3, 1'b0, 1'b0);
    step(1'b1, 4'h4, 1'b0, 1'b0);
    idle();
    rst = 1'b1;
    #1;
    check("t5 in_ready", in_ready, 0);
    check("t5 out_valid", out_valid, 0);
    check("t5 count", count, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check("t5 in_ready release", in_ready, 1);
    step(1'b1, 4'hf, 1'b0, 1'b0);
    idle();
    check("t5 first pop", out_data, 4'hf);
    step(1'b0, '0, 1'b1, 1'b0);
    idle();
    check("t5 empty", empty, 1);

    // 6. Protocol: legal hold under full, then a dropped offer
    for (int i = 1; i <= 4; i++) step(1'b1, N'(i), 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b0, 1'b0);
    #1 check("t6 hold proto_err", proto_err, 0);
    step(1'b1, 4'h5, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = 4'h5;
    #1 check("t6 hold accepted", rf_we, 1);
    step(1'b1, 4'h5, 1'b0, 1'b0);
    idle();
    check("t6 legal proto_err", proto_err, 0);
    check("t6 count", count, 4);
    step(1'b1, 4'h6, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    idle();
    check("t6 violation", proto_err, 1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
    check("t6 sticky", proto_err, 1);
    step(1'b0, '0, 1'b0, 1'b1);
    idle();
    check("t6 kept over flush", proto_err, 1);
    check("t6 flush count", count, 0);

    step(1'b0, '0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
